// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one valid/ready memory port between the IFU and the LSU.
// Define MEM_ARB_TIMEOUT_EN to enable the WAIT-state timeout with error response.
module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int MASK_W = DATA_W / 8;
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEADBEEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic               last_grant_reg, last_grant_next;
    logic               owner_reg, owner_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic               wen_reg, wen_next;
    logic [DATA_W-1:0]  wdata_reg, wdata_next;
    logic [MASK_W-1:0]  wmask_reg, wmask_next;
    logic [DATA_W-1:0]  ifu_rdata_reg, ifu_rdata_next;
    logic [DATA_W-1:0]  lsu_rdata_reg, lsu_rdata_next;
    logic               ifu_resp_valid_reg, ifu_resp_valid_next;
    logic               lsu_resp_valid_reg, lsu_resp_valid_next;
    logic               grant_ifu, grant_lsu;
    logic               timeout_hit;
    logic               resp_fire;
    logic [DATA_W-1:0]  resp_data;

    // Arbitration is only live in IDLE; a tie goes to whoever was not served last.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state_reg == IDLE && !rst) begin
            if (ifu_req_valid && lsu_req_valid) begin
                grant_lsu = (last_grant_reg == OWN_IFU);
                grant_ifu = (last_grant_reg == OWN_LSU);
            end else begin
                grant_ifu = ifu_req_valid;
                grant_lsu = lsu_req_valid;
            end
        end
    end

    always_comb begin
        state_next          = state_reg;
        last_grant_next     = last_grant_reg;
        owner_next          = owner_reg;
        addr_next           = addr_reg;
        wen_next            = wen_reg;
        wdata_next          = wdata_reg;
        wmask_next          = wmask_reg;
        ifu_rdata_next      = ifu_rdata_reg;
        lsu_rdata_next      = lsu_rdata_reg;
        ifu_resp_valid_next = 1'b0;
        lsu_resp_valid_next = 1'b0;
        resp_fire           = 1'b0;
        resp_data           = '0;

        case (state_reg)
            IDLE: begin
                if (grant_ifu) begin
                    owner_next      = OWN_IFU;
                    last_grant_next = OWN_IFU;
                    addr_next       = ifu_addr;
                    wen_next        = 1'b0;
                    wdata_next      = '0;
                    wmask_next      = '0;
                    state_next      = REQ;
                end else if (grant_lsu) begin
                    owner_next      = OWN_LSU;
                    last_grant_next = OWN_LSU;
                    addr_next       = lsu_addr;
                    wen_next        = lsu_wen;
                    wdata_next      = lsu_wdata;
                    wmask_next      = lsu_wmask;
                    state_next      = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // A real response beats a timeout landing in the same cycle.
                if (mem_resp_valid) begin
                    resp_fire  = 1'b1;
                    resp_data  = wen_reg ? '0 : mem_rdata;
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    resp_fire  = 1'b1;
                    resp_data  = TIMEOUT_DATA;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (resp_fire) begin
            if (owner_reg == OWN_IFU) begin
                ifu_resp_valid_next = 1'b1;
                ifu_rdata_next      = resp_data;
            end else begin
                lsu_resp_valid_next = 1'b1;
                lsu_rdata_next      = resp_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= IDLE;
            last_grant_reg     <= OWN_IFU;
            owner_reg          <= OWN_IFU;
            addr_reg           <= '0;
            wen_reg            <= 1'b0;
            wdata_reg          <= '0;
            wmask_reg          <= '0;
            ifu_rdata_reg      <= '0;
            lsu_rdata_reg      <= '0;
            ifu_resp_valid_reg <= 1'b0;
            lsu_resp_valid_reg <= 1'b0;
        end else begin
            state_reg          <= state_next;
            last_grant_reg     <= last_grant_next;
            owner_reg          <= owner_next;
            addr_reg           <= addr_next;
            wen_reg            <= wen_next;
            wdata_reg          <= wdata_next;
            wmask_reg          <= wmask_next;
            ifu_rdata_reg      <= ifu_rdata_next;
            lsu_rdata_reg      <= lsu_rdata_next;
            ifu_resp_valid_reg <= ifu_resp_valid_next;
            lsu_resp_valid_reg <= lsu_resp_valid_next;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             ifu_err_reg, ifu_err_next;
    logic             lsu_err_reg, lsu_err_next;

    assign timeout_hit = (state_reg == WAIT) && (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES));

    // Counter sits at zero outside WAIT so it always starts clean on entry.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (state_reg != WAIT) begin
            wait_cnt_next = '0;
        end else if (!mem_resp_valid && !timeout_hit) begin
            wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        end
        ifu_err_next = timeout_hit && !mem_resp_valid && (owner_reg == OWN_IFU);
        lsu_err_next = timeout_hit && !mem_resp_valid && (owner_reg == OWN_LSU);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg <= '0;
            ifu_err_reg  <= 1'b0;
            lsu_err_reg  <= 1'b0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            ifu_err_reg  <= ifu_err_next;
            lsu_err_reg  <= lsu_err_next;
        end
    end

    assign ifu_resp_err = ifu_err_reg;
    assign lsu_resp_err = lsu_err_reg;
`else
    assign timeout_hit  = 1'b0;
    assign ifu_resp_err = 1'b0;
    assign lsu_resp_err = 1'b0;
`endif

    assign ifu_req_ready  = grant_ifu;
    assign lsu_req_ready  = grant_lsu;
    assign ifu_resp_valid = ifu_resp_valid_reg;
    assign lsu_resp_valid = lsu_resp_valid_reg;
    assign ifu_rdata      = ifu_rdata_reg;
    assign lsu_rdata      = lsu_rdata_reg;
    assign mem_req_valid  = (state_reg == REQ);
    assign mem_addr       = addr_reg;
    assign mem_wen        = wen_reg;
    assign mem_wdata      = wdata_reg;
    assign mem_wmask      = wmask_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a bench-side memory responder, a transaction-level
// reference model checked every cycle, and literal expectations for each scenario.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic [MW-1:0] lsu_wmask;
    logic          mem_req_valid, mem_wen;
    logic          mem_req_ready = 1'b0;
    logic          mem_resp_valid = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [MW-1:0] mem_wmask;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Memory responder: optional ready stall, response one cycle after the handshake.
    int          ready_delay = 0;
    int          stall_cnt   = 0;
    int          resp_cd     = 0;
    bit          no_resp     = 0;
    bit          inject_resp = 0;
    bit          rsp_random  = 0;
    logic [31:0] rsp_data    = '0;

    always @(posedge clk) begin
        #1;
        mem_resp_valid = 1'b0;
        if (inject_resp) begin
            mem_resp_valid = 1'b1;
            mem_rdata      = $urandom;
            inject_resp    = 0;
        end
        if (resp_cd > 0) begin
            resp_cd--;
            if (resp_cd == 0) begin
                mem_resp_valid = 1'b1;
                mem_rdata      = rsp_random ? $urandom : rsp_data;
            end
        end
        if (mem_req_valid && !mem_req_ready) begin
            if (stall_cnt < ready_delay) begin
                stall_cnt++;
            end else begin
                mem_req_ready = 1'b1;
                stall_cnt     = 0;
                if (!no_resp) resp_cd = 1;
            end
        end else begin
            mem_req_ready = 1'b0;
        end
    end

    // Transaction-level reference model.
    typedef enum {M_IDLE, M_REQ, M_WAIT} mphase_t;
    typedef struct {
        logic        own;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } txn_t;

    mphase_t     phase = M_IDLE;
    txn_t        cur;
    logic        last_own = 1'b0;
    bit          resp_pending = 0;
    logic        resp_own = 1'b0;
    logic [31:0] resp_val = '0;
    logic        resp_err_exp = 1'b0;
    logic [31:0] exp_rdata [2];
    int          wait_cnt = 0;
    int          cycle = 0;
    int          accept_cycle = 0;
    int          resp_cycle = 0;
    int          resp_count = 0;
    int          stall_cycles = 0;
    int          txn_no = 0;
    bit          err_seen = 0;
    logic        grant_q [$];

    always @(negedge clk) begin
        logic exp_ifu_rdy, exp_lsu_rdy;
        cycle++;
        if (rst) begin
            phase        = M_IDLE;
            last_own     = 1'b0;
            resp_pending = 0;
            exp_rdata[0] = '0;
            exp_rdata[1] = '0;
            wait_cnt     = 0;
        end else begin
            chk("ifu_resp_valid", ifu_resp_valid, resp_pending && resp_own == 1'b0);
            chk("lsu_resp_valid", lsu_resp_valid, resp_pending && resp_own == 1'b1);
            chk("ifu_resp_err", ifu_resp_err, resp_pending && resp_own == 1'b0 && resp_err_exp);
            chk("lsu_resp_err", lsu_resp_err, resp_pending && resp_own == 1'b1 && resp_err_exp);
            if (lsu_resp_err) err_seen = 1;
            if (resp_pending) begin
                exp_rdata[resp_own] = resp_val;
                resp_count++;
                resp_cycle = cycle;
            end
            chk("ifu_rdata", ifu_rdata, exp_rdata[0]);
            chk("lsu_rdata", lsu_rdata, exp_rdata[1]);
            resp_pending = 0;

            chk("mem_req_valid", mem_req_valid, phase == M_REQ);
            if (phase == M_REQ) begin
                chk("mem_addr", mem_addr, cur.addr);
                chk("mem_wen", mem_wen, cur.wen);
                chk("mem_wmask", mem_wmask, cur.wmask);
                if (cur.own) chk("mem_wdata", mem_wdata, cur.wdata);
                if (!mem_req_ready) stall_cycles++;
            end

            exp_ifu_rdy = 1'b0;
            exp_lsu_rdy = 1'b0;
            if (phase == M_IDLE) begin
                if (ifu_req_valid && lsu_req_valid) begin
                    if (last_own == 1'b0) exp_lsu_rdy = 1'b1;
                    else                  exp_ifu_rdy = 1'b1;
                end else begin
                    exp_ifu_rdy = ifu_req_valid;
                    exp_lsu_rdy = lsu_req_valid;
                end
            end
            chk("ifu_req_ready", ifu_req_ready, exp_ifu_rdy);
            chk("lsu_req_ready", lsu_req_ready, exp_lsu_rdy);

            case (phase)
                M_IDLE: begin
                    if (exp_ifu_rdy || exp_lsu_rdy) begin
                        cur.own   = exp_lsu_rdy;
                        cur.addr  = exp_lsu_rdy ? lsu_addr : ifu_addr;
                        cur.wen   = exp_lsu_rdy ? lsu_wen : 1'b0;
                        cur.wdata = exp_lsu_rdy ? lsu_wdata : 32'h0;
                        cur.wmask = exp_lsu_rdy ? lsu_wmask : 4'h0;
                        last_own  = cur.own;
                        grant_q.push_back(cur.own);
                        accept_cycle = cycle;
                        phase = M_REQ;
                    end
                end
                M_REQ: begin
                    if (mem_req_ready) begin
                        phase    = M_WAIT;
                        wait_cnt = 0;
                    end
                end
                M_WAIT: begin
                    if (mem_resp_valid) begin
                        resp_pending = 1;
                        resp_own     = cur.own;
                        resp_val     = cur.wen ? 32'h0 : mem_rdata;
                        resp_err_exp = 1'b0;
                        phase        = M_IDLE;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (wait_cnt == TO) begin
                        resp_pending = 1;
                        resp_own     = cur.own;
                        resp_val     = 32'hDEADBEEF;
                        resp_err_exp = 1'b1;
                        phase        = M_IDLE;
                    end else begin
                        wait_cnt++;
                    end
`endif
                    if (resp_pending) begin
                        txn_no++;
                        $display("txn %0d: %s %s addr=0x%08h data=0x%08h err=%0b", txn_no,
                                 cur.own ? "LSU" : "IFU", cur.wen ? "store" : "load",
                                 cur.addr, resp_val, resp_err_exp);
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic nedge();
        @(negedge clk);
        #1;
    endtask

    task automatic pedge();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the accepting edge.
    task automatic wait_ready(input bit is_lsu);
        int n = 0;
        forever begin
            nedge();
            if (is_lsu ? lsu_req_ready : ifu_req_ready) break;
            if (++n > 100) begin
                bound_fail(is_lsu ? "lsu_accept" : "ifu_accept");
                break;
            end
        end
        pedge();
    endtask

    task automatic wait_resp(input int target);
        int n = 0;
        while (resp_count < target) begin
            nedge();
            if (++n > 100) begin
                bound_fail("response");
                break;
            end
        end
    endtask

    task automatic wait_phase_wait();
        int n = 0;
        while (phase != M_WAIT) begin
            nedge();
            if (++n > 100) begin
                bound_fail("enter_wait");
                break;
            end
        end
    endtask

    initial begin
        int base;
        rst = 1'b1;
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        repeat (3) pedge();
        rst = 1'b0;
        nedge();

        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wen", mem_wen, 1'b0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wmask", mem_wmask, 4'h0);
        chk("rst_ifu_rdata", ifu_rdata, 32'h0);
        chk("rst_lsu_rdata", lsu_rdata, 32'h0);
        chk("rst_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        chk("rst_resp_err", {ifu_resp_err, lsu_resp_err}, 2'b00);

        // IFU-only read at minimum latency.
        rsp_data = 32'h00000413;
        pedge();
        ifu_req_valid = 1'b1; ifu_addr = 32'h80000000;
        wait_ready(1'b0);
        ifu_req_valid = 1'b0;
        wait_resp(1);
        chk("t1_ifu_rdata", ifu_rdata, 32'h00000413);
        chk("t1_latency", resp_cycle - accept_cycle, 3);

        // Both masters always valid: grant order LSU, IFU, LSU.
        grant_q.delete();
        rsp_random = 1;
        base = resp_count;
        pedge();
        ifu_req_valid = 1'b1; ifu_addr = 32'h80000010;
        lsu_req_valid = 1'b1; lsu_addr = 32'h80002000; lsu_wen = 1'b0; lsu_wmask = 4'hF;
        begin
            int n = 0;
            while (grant_q.size() < 3) begin
                nedge();
                if (++n > 100) begin
                    bound_fail("t3_grants");
                    break;
                end
            end
        end
        pedge();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        wait_resp(base + 3);
        chk("t3_grant_count", grant_q.size(), 3);
        if (grant_q.size() >= 3) begin
            chk("t3_grant0", grant_q[0], 1'b1);
            chk("t3_grant1", grant_q[1], 1'b0);
            chk("t3_grant2", grant_q[2], 1'b1);
        end

        // LSU store: fields on the bus, zero read data returned.
        rsp_random = 0;
        rsp_data   = 32'hFFFFFFFF;
        base = resp_count;
        pedge();
        lsu_req_valid = 1'b1; lsu_addr = 32'h80001000; lsu_wen = 1'b1;
        lsu_wdata = 32'h12345678; lsu_wmask = 4'b0011;
        wait_ready(1'b1);
        lsu_req_valid = 1'b0;
        nedge();
        chk("t2_mem_valid", mem_req_valid, 1'b1);
        chk("t2_mem_addr", mem_addr, 32'h80001000);
        chk("t2_mem_wen", mem_wen, 1'b1);
        chk("t2_mem_wdata", mem_wdata, 32'h12345678);
        chk("t2_mem_wmask", mem_wmask, 4'b0011);
        wait_resp(base + 1);
        chk("t2_lsu_rdata", lsu_rdata, 32'h0);
        lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = 4'hF;

        // Backpressure: five stalled cycles per request, LSU held off meanwhile.
        ready_delay  = 5;
        stall_cycles = 0;
        rsp_random   = 1;
        base = resp_count;
        pedge();
        ifu_req_valid = 1'b1; ifu_addr = 32'h80000020;
        wait_ready(1'b0);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b1; lsu_addr = 32'h80003000;
        wait_ready(1'b1);
        lsu_req_valid = 1'b0;
        wait_resp(base + 2);
        chk("t4_stall_cycles", stall_cycles, 10);
        ready_delay = 0;

        // Reset in WAIT; the late response must be dropped.
        no_resp = 1;
        pedge();
        ifu_req_valid = 1'b1; ifu_addr = 32'h80000040;
        wait_ready(1'b0);
        ifu_req_valid = 1'b0;
        wait_phase_wait();
        nedge();
        base = resp_count;
        pedge();
        rst = 1'b1;
        pedge();
        rst = 1'b0;
        inject_resp = 1;
        repeat (5) nedge();
        chk("t5_no_resp", resp_count, base);
        chk("t5_ifu_rdata_cleared", ifu_rdata, 32'h0);
        no_resp    = 0;
        rsp_random = 0;
        rsp_data   = 32'h00100093;
        pedge();
        ifu_req_valid = 1'b1; ifu_addr = 32'h80000044;
        wait_ready(1'b0);
        ifu_req_valid = 1'b0;
        wait_resp(base + 1);
        chk("t5_ifu_rdata", ifu_rdata, 32'h00100093);

        // Memory never answers.
        no_resp = 1;
        base = resp_count;
        pedge();
        lsu_req_valid = 1'b1; lsu_addr = 32'h80004000; lsu_wen = 1'b0;
        wait_ready(1'b1);
        lsu_req_valid = 1'b0;
        wait_phase_wait();
`ifdef MEM_ARB_TIMEOUT_EN
        wait_resp(base + 1);
        chk("t6_lsu_rdata", lsu_rdata, 32'hDEADBEEF);
        chk("t6_err_seen", err_seen, 1'b1);
`else
        repeat (20) nedge();
        chk("t6_no_resp", resp_count, base);
        chk("t6_still_waiting", mem_req_valid, 1'b0);
        pedge();
        rst = 1'b1;
        pedge();
        rst = 1'b0;
        nedge();
`endif
        no_resp = 0;
        nedge();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
